// File: rtl/count_sched.sv
// Round-robin burst scheduler: grants one requester at a time a counting burst
// on a shared modulo-MOD tick counter, with hold, abort and a one-cycle done pulse.
module count_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned MOD  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] len,
  input  logic              hold,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [3:0]        cnt,
  output logic              done,
  output logic [1:0]        done_id
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   last_winner;
  logic [3:0]      remaining;

  logic [IW-1:0]   pick_c;
  logic [IW-1:0]   idx_c;
  logic            found_c;
  logic [3:0]      len_raw_c;
  logic [3:0]      len_c;
  logic [3:0]      len_arr [NREQ];

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_len
    assign len_arr[g] = len[4*g +: 4];
  end

  // Round-robin search starting just after the previous winner
  always_comb begin
    pick_c  = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx_c = IW'((int'(last_winner) + k) % int'(NREQ));
      if (!found_c && req[idx_c]) begin
        found_c = 1'b1;
        pick_c  = idx_c;
      end
    end
  end

  // Out-of-range burst lengths (0 or above MOD) run a full MOD ticks
  always_comb begin
    len_raw_c = len_arr[pick_c];
    len_c     = len_raw_c;
    if (len_raw_c == 4'd0 || len_raw_c > 4'(MOD)) len_c = 4'(MOD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      busy        <= 1'b0;
      cnt         <= '0;
      done        <= 1'b0;
      done_id     <= '0;
      remaining   <= '0;
      winner      <= '0;
      last_winner <= IW'(NREQ - 1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (found_c) begin
            winner    <= pick_c;
            gnt       <= NREQ'(1) << pick_c;
            busy      <= 1'b1;
            cnt       <= '0;
            remaining <= len_c;
            state     <= RUN;
          end
        end
        RUN: begin
          // Dropping the winner's request aborts, even on the final tick
          if (!req[winner]) begin
            gnt         <= '0;
            busy        <= 1'b0;
            last_winner <= winner;
            state       <= IDLE;
          end else if (!hold) begin
            cnt       <= (cnt == 4'(MOD - 1)) ? 4'd0 : cnt + 4'd1;
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              gnt         <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
              done_id     <= 2'(winner);
              last_winner <= winner;
              state       <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_count_sched;

  localparam int NREQ = 4;
  localparam int MOD  = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] len;
  logic        hold;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  cnt;
  logic        done;
  logic [1:0]  done_id;

  count_sched #(.NREQ(NREQ), .MOD(MOD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len(len), .hold(hold),
    .gnt(gnt), .busy(busy), .cnt(cnt), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Burst-level model: an active burst, a cooldown cycle after completion
  bit m_active = 0, m_cool = 0, m_done = 0;
  int m_win = 0, m_rem = 0, m_cnt = 0, m_last = NREQ - 1, m_did = 0;

  function automatic int eff_len(input int w);
    int v;
    v = int'((len >> (4 * w)) & 16'hF);
    if (v == 0 || v > MOD) v = MOD;
    return v;
  endfunction

  task automatic m_reset();
    m_active = 0; m_cool = 0; m_done = 0;
    m_win = 0; m_rem = 0; m_cnt = 0; m_last = NREQ - 1; m_did = 0;
  endtask

  task automatic m_step();
    if (m_cool) begin
      m_cool = 0;
      m_done = 0;
    end else if (m_active) begin
      if (!req[m_win]) begin
        m_active = 0;
        m_last   = m_win;
      end else if (!hold) begin
        m_cnt = (m_cnt + 1) % MOD;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_active = 0; m_done = 1; m_did = m_win; m_last = m_win; m_cool = 1;
        end
      end
    end else if (req != 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (req[(m_last + k) % NREQ]) begin
          m_win = (m_last + k) % NREQ;
          break;
        end
      end
      m_active = 1;
      m_cnt    = 0;
      m_rem    = eff_len(m_win);
    end
  endtask

  always @(negedge rst_n) m_reset();
  always @(posedge clk) if (rst_n) m_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 32'(gnt), m_active ? 32'(1 << m_win) : 32'd0);
      chk("busy", 32'(busy), 32'(m_active));
      chk("cnt", 32'(cnt), 32'(m_cnt));
      chk("done", 32'(done), 32'(m_done));
      if (m_done) chk("done_id", 32'(done_id), 32'(m_did));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    end
  end

  task automatic nc();
    @(negedge clk);
  endtask

  initial begin
    int got [5];
    int ng;
    int guard;
    logic [3:0] flip;

    rst_n = 1'b0; req = '0; len = '0; hold = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk_en = 1'b1;
    nc(); nc();
    rst_n = 1'b1;

    // Single burst of 3
    nc(); req = 4'b0001; len = 16'h0003;
    nc(); chk("sb_gnt", 32'(gnt), 32'd1); chk("sb_cnt0", 32'(cnt), 32'd0);
    nc(); chk("sb_cnt1", 32'(cnt), 32'd1);
    nc(); chk("sb_cnt2", 32'(cnt), 32'd2); chk("sb_gnt2", 32'(gnt), 32'd1);
    nc(); chk("sb_done", 32'(done), 32'd1); chk("sb_did", 32'(done_id), 32'd0);
    chk("sb_gnt_done", 32'(gnt), 32'd0); chk("sb_cnt3", 32'(cnt), 32'd3);
    req = '0;
    nc(); chk("sb_done_pulse", 32'(done), 32'd0);

    // Full-modulus wrap, with len 12 then len 0
    for (int p = 0; p < 2; p++) begin
      req = 4'b0010; len = (p == 0) ? 16'h00C0 : 16'h0000;
      nc(); chk("wr_gnt", 32'(gnt), 32'd2); chk("wr_cnt0", 32'(cnt), 32'd0);
      for (int i = 1; i < 12; i++) begin
        nc(); chk("wr_cnt", 32'(cnt), 32'(i)); chk("wr_nodone", 32'(done), 32'd0);
      end
      nc(); chk("wr_done", 32'(done), 32'd1); chk("wr_cnt_wrap", 32'(cnt), 32'd0);
      chk("wr_did", 32'(done_id), 32'd1);
      req = '0;
      nc();
    end

    // Round-robin from a fresh reset
    #2 rst_n = 1'b0;
    nc();
    #2 rst_n = 1'b1; req = 4'hF; len = 16'h1111;
    ng = 0; guard = 0;
    while (ng < 5 && guard < 40) begin
      nc(); guard++;
      if (gnt != 0) begin got[ng] = int'(gnt); ng++; end
    end
    chk("rr_count", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(got[i]), 32'(1 << (i % 4)));
    req = '0;
    nc(); nc();

    // Hold for 3 cycles after the second increment
    req = 4'b0100; len = 16'h0400;
    nc(); chk("hd_gnt", 32'(gnt), 32'd4); chk("hd_cnt0", 32'(cnt), 32'd0);
    nc(); chk("hd_cnt1", 32'(cnt), 32'd1);
    nc(); chk("hd_cnt2", 32'(cnt), 32'd2); hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nc(); chk("hd_held", 32'(cnt), 32'd2); chk("hd_gnt_held", 32'(gnt), 32'd4);
    end
    hold = 1'b0;
    nc(); chk("hd_cnt3", 32'(cnt), 32'd3); chk("hd_nodone", 32'(done), 32'd0);
    nc(); chk("hd_done", 32'(done), 32'd1); chk("hd_cnt4", 32'(cnt), 32'd4);
    chk("hd_did", 32'(done_id), 32'd2);
    req = '0;
    nc();

    // Abort at cnt=5 with requester 1 waiting
    req = 4'b0001; len = 16'h0008;
    nc(); chk("ab_gnt", 32'(gnt), 32'd1);
    for (int i = 1; i <= 5; i++) begin nc(); chk("ab_cnt", 32'(cnt), 32'(i)); end
    req = 4'b0010;
    nc(); chk("ab_gnt0", 32'(gnt), 32'd0); chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_nodone", 32'(done), 32'd0); chk("ab_cnt_hold", 32'(cnt), 32'd5);
    nc(); chk("ab_next_gnt", 32'(gnt), 32'd2); chk("ab_next_cnt", 32'(cnt), 32'd0);
    req = '0;
    nc(); nc();

    // Asynchronous reset between edges mid-burst
    req = 4'b0001; len = 16'h0008;
    nc(); nc(); nc();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'd0); chk("ar_cnt", 32'(cnt), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0); chk("ar_done", 32'(done), 32'd0);
    #1 rst_n = 1'b1; req = 4'b1000;
    nc(); chk("ar_gnt_after", 32'(gnt), 32'd8);
    req = '0;
    nc(); nc();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      nc();
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 7) == 0);
      req  = req ^ flip;
      len  = 16'($urandom);
      hold = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        nc();
        #2 rst_n = 1'b1;
      end
    end

    nc();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
